sdram_device: RTL and testbench

Synthesizable responder model of a 4-bank, x16 SDR SDRAM with burst length 1 or 2 and CAS latency 2 or 3. It decodes the command bus, tracks the mode register and per-bank open rows, stores written data in a reduced on-chip array, and returns read bursts with correct CAS and DQM latency. It also latches protocol violations. It sits opposite our SDRAM controller in simulation and FPGA loopback builds; a top-level wrapper builds the tristate DQ from dq_out/dq_oe.

---
 rtl/sdram_pkg.sv | 53 +++++
 rtl/sdram_rd_pipe.sv | 81 ++++++++
 rtl/sdram_device.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_device.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: command, mode, error and state encodings shared by the
// SDR SDRAM responder model.
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_BST = 4'b0110,
        CMD_NOP = 4'b0111
    } cmd_t;

    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_WB_BIT = 9;
    localparam int A10_BIT     = 10;

    localparam logic [2:0] BL_1 = 3'b000;
    localparam logic [2:0] BL_2 = 3'b001;
    localparam logic [2:0] CL_2 = 3'b010;
    localparam logic [2:0] CL_3 = 3'b011;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_NOT_INIT     = 3'd1,
        ERR_BANK_IDLE    = 3'd2,
        ERR_BANK_OPEN    = 3'd3,
        ERR_REFRESH_OPEN = 3'd4,
        ERR_TIMING       = 3'd5,
        ERR_BAD_MODE     = 3'd6
    } err_t;

    typedef enum logic {
        BANK_IDLE = 1'b0,
        BANK_OPEN = 1'b1
    } bank_st_t;

    typedef enum logic [1:0] {
        INIT_POWERUP,
        INIT_PRE_DONE,
        INIT_READY
    } init_t;

    function automatic logic mode_ok(input logic [2:0] bl, input logic [2:0] cl);
        return ((bl == BL_1) || (bl == BL_2)) && ((cl == CL_2) || (cl == CL_3));
    endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// sdram_rd_pipe: read-beat shift pipeline placing beats by CAS latency,
// with the DQM delay stage and the registered DQ drive.
module sdram_rd_pipe
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cke,
    input  logic                           start,
    input  logic                           cancel,
    input  logic                           cl3,
    input  logic                           bl2,
    input  logic [1:0]                     bank,
    input  logic [ROW_BITS-1:0]            row,
    input  logic [COL_BITS-1:0]            col,
    input  logic [1:0]                     dqm,
    output logic [2+ROW_BITS+COL_BITS-1:0] rd_addr,
    input  logic [15:0]                    rd_data,
    output logic [15:0]                    dq_out,
    output logic                           dq_oe
);

    typedef struct packed {
        logic                valid;
        logic [1:0]          bank;
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic                beat;
    } beat_t;

    beat_t [2:0] pipe;
    beat_t       b0;
    beat_t       b1;
    logic        dqm_d;

    always_comb begin
        b0       = '0;
        b1       = '0;
        b0.valid = 1'b1;
        b0.bank  = bank;
        b0.row   = row;
        b0.col   = col;
        b0.beat  = 1'b0;
        if (bl2) begin
            b1      = b0;
            b1.beat = 1'b1;
        end
    end

    // beat 1 toggles col[0], which gives the wrap order for both parities
    assign rd_addr = {pipe[0].bank, pipe[0].row,
                      pipe[0].col ^ COL_BITS'(pipe[0].beat)};

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe   <= '0;
            dqm_d  <= 1'b0;
            dq_out <= '0;
            dq_oe  <= 1'b0;
        end else if (cke) begin
            dqm_d <= |dqm;
            dq_oe <= pipe[0].valid && !dqm_d;
            if (pipe[0].valid) begin
                dq_out <= rd_data;
            end
            if (start && cl3) begin
                pipe <= {b1, b0, beat_t'(0)};
            end else if (start) begin
                pipe <= {beat_t'(0), b1, b0};
            end else if (cancel) begin
                pipe <= '0;
            end else begin
                pipe <= {beat_t'(0), pipe[2:1]};
            end
        end
    end

endmodule

// File: rtl/sdram_device.sv
// sdram_device: x16 4-bank SDR SDRAM responder with init tracking, bank
// table, reduced storage, read bursts and a sticky protocol-error latch.
module sdram_device
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 8,
    parameter int T_RFC    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [1:0]  ba,
    input  logic [12:0] a,
    input  logic [1:0]  dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int RW    = $clog2(T_RFC + 1);

    cmd_t                cmd;
    logic                is_pre;
    logic                is_ref;
    logic                is_lmr;
    logic                is_act;
    logic                is_rd;
    logic                is_wr;
    logic                is_live;
    init_t               init_st;
    init_t               init_nx;
    bank_st_t            bank_st [4];
    logic [ROW_BITS-1:0] bank_row [4];
    logic [3:0]          open_vec;
    logic [RW-1:0]       rfc_cnt;
    logic [1:0]          ref_cnt;
    logic                mode_bl2;
    logic                mode_cl3;
    logic                mode_wsingle;
    logic                err_hit;
    err_t                err_val;
    logic                acc;
    logic                err_q;
    err_t                code_q;
    logic                wr_pend;
    logic [AW-1:0]       wr_pend_addr;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [15:0]         wr_data;
    logic [1:0]          wr_be;
    logic [AW-1:0]       addr0;
    logic [AW-1:0]       rd_addr;
    logic [15:0]         rd_data;
    logic [15:0]         mem [DEPTH];
    logic                unused_a;

    assign cmd     = cs_n ? CMD_NOP : cmd_t'({1'b0, ras_n, cas_n, we_n});
    assign is_pre  = (cmd == CMD_PRE);
    assign is_ref  = (cmd == CMD_REF);
    assign is_lmr  = (cmd == CMD_LMR);
    assign is_act  = (cmd == CMD_ACT);
    assign is_rd   = (cmd == CMD_RD);
    assign is_wr   = (cmd == CMD_WR);
    assign is_live = (cmd != CMD_NOP);

    // upper row/column bits alias onto the reduced array
    assign unused_a = ^a;
    assign addr0    = {ba, bank_row[ba], a[COL_BITS-1:0]};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            open_vec[i] = (bank_st[i] == BANK_OPEN);
        end
    end

    always_comb begin
        err_hit = 1'b0;
        err_val = ERR_NONE;
        if (cke && is_live) begin
            err_hit = 1'b1;
            if (rfc_cnt != '0) begin
                err_val = ERR_TIMING;
            end else if ((is_act || is_rd || is_wr) && init_st != INIT_READY) begin
                err_val = ERR_NOT_INIT;
            end else if (is_act && open_vec[ba]) begin
                err_val = ERR_BANK_OPEN;
            end else if ((is_rd || is_wr) && !open_vec[ba]) begin
                err_val = ERR_BANK_IDLE;
            end else if ((is_ref || is_lmr) && (|open_vec)) begin
                err_val = ERR_REFRESH_OPEN;
            end else if (is_lmr && !mode_ok(a[MODE_BL_MSB:MODE_BL_LSB],
                                            a[MODE_CL_MSB:MODE_CL_LSB])) begin
                err_val = ERR_BAD_MODE;
            end else begin
                err_hit = 1'b0;
            end
        end
    end

    assign acc = cke && is_live && !err_hit;

    always_comb begin
        init_nx = init_st;
        unique case (init_st)
            INIT_POWERUP: begin
                if (acc && is_pre && a[A10_BIT]) init_nx = INIT_PRE_DONE;
            end
            INIT_PRE_DONE: begin
                if (acc && is_lmr && ref_cnt == 2'd2) init_nx = INIT_READY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_st      <= INIT_POWERUP;
            ref_cnt      <= '0;
            rfc_cnt      <= '0;
            mode_bl2     <= 1'b0;
            mode_cl3     <= 1'b0;
            mode_wsingle <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
            wr_pend      <= 1'b0;
            wr_pend_addr <= '0;
            for (int i = 0; i < 4; i++) begin
                bank_st[i]  <= BANK_IDLE;
                bank_row[i] <= '0;
            end
        end else if (cke) begin
            init_st <= init_nx;
            if (rfc_cnt != '0) rfc_cnt <= rfc_cnt - 1'b1;
            if (err_hit && !err_q) begin
                err_q  <= 1'b1;
                code_q <= err_val;
            end
            wr_pend      <= acc && is_wr && mode_bl2 && !mode_wsingle;
            wr_pend_addr <= addr0 ^ AW'(1);
            if (acc) begin
                unique case (1'b1)
                    is_pre: begin
                        for (int i = 0; i < 4; i++) begin
                            if (a[A10_BIT] || ba == 2'(i)) bank_st[i] <= BANK_IDLE;
                        end
                    end
                    is_ref: begin
                        rfc_cnt <= RW'(T_RFC);
                        if (init_st == INIT_PRE_DONE && ref_cnt != 2'd2) begin
                            ref_cnt <= ref_cnt + 2'd1;
                        end
                    end
                    is_lmr: begin
                        mode_bl2     <= (a[MODE_BL_MSB:MODE_BL_LSB] == BL_2);
                        mode_cl3     <= (a[MODE_CL_MSB:MODE_CL_LSB] == CL_3);
                        mode_wsingle <= a[MODE_WB_BIT];
                    end
                    is_act: begin
                        bank_st[ba]  <= BANK_OPEN;
                        bank_row[ba] <= a[ROW_BITS-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // a new READ or WRITE takes the data bus from a pending write beat
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr0;
        wr_data = dq_in;
        wr_be   = ~dqm;
        if (!rst && cke) begin
            if (acc && is_wr) begin
                wr_en = 1'b1;
            end else if (wr_pend && !(acc && is_rd)) begin
                wr_en   = 1'b1;
                wr_addr = wr_pend_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
            if (wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
        end
    end

    assign rd_data = mem[rd_addr];

    sdram_rd_pipe #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .cke     (cke),
        .start   (acc && is_rd),
        .cancel  (acc && is_wr),
        .cl3     (mode_cl3),
        .bl2     (mode_bl2),
        .bank    (ba),
        .row     (bank_row[ba]),
        .col     (a[COL_BITS-1:0]),
        .dqm     (dqm),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dq_out  (dq_out),
        .dq_oe   (dq_oe)
    );

    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_sdram_device.sv
// tb_sdram_device: directed and randomized bench against a timeline-based
// behavioural SDRAM model.
module tb_sdram_device;

    localparam int T_RFC = 3;
    localparam int NROW  = 4;
    localparam int NCOL  = 256;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] a = '0;
    logic [1:0]  dqm = '0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        err;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    sdram_device #(
        .ROW_BITS (2),
        .COL_BITS (8),
        .T_RFC    (T_RFC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cke      (cke),
        .cs_n     (cs_n),
        .ras_n    (ras_n),
        .cas_n    (cas_n),
        .we_n     (we_n),
        .ba       (ba),
        .a        (a),
        .dqm      (dqm),
        .dq_in    (dq_in),
        .dq_out   (dq_out),
        .dq_oe    (dq_oe),
        .err      (err),
        .err_code (err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    typedef struct {
        int t;
        int addr;
    } beat_s;

    int          t = 0;
    int          m_init, m_refs, m_rfc_until;
    bit          m_bl2, m_cl3, m_ws;
    bit          m_open [4];
    int          m_row [4];
    logic [15:0] m_mem [NROW*NCOL*4];
    logic [15:0] m_known [NROW*NCOL*4];
    beat_s       q[$];
    bit          m_mask;
    bit          m_pend;
    int          m_pend_addr;
    bit          m_err;
    int          m_code;
    logic [15:0] e_out, e_known;
    bit          e_oe;

    function automatic int idx(input int b, input int row, input int col);
        return b * NROW * NCOL + (row % NROW) * NCOL + (col % NCOL);
    endfunction

    task automatic model_reset();
        m_init = 0; m_refs = 0; m_rfc_until = -100;
        m_bl2 = 0; m_cl3 = 0; m_ws = 0;
        for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_row[i] = 0; end
        q.delete();
        m_mask = 0; m_pend = 0; m_pend_addr = 0;
        m_err = 0; m_code = 0;
        e_out = '0; e_known = 16'hFFFF; e_oe = 0;
    endtask

    task automatic mwrite(input int ad);
        if (!dqm[1]) begin m_mem[ad][15:8] = dq_in[15:8]; m_known[ad][15:8] = 8'hFF; end
        if (!dqm[0]) begin m_mem[ad][7:0]  = dq_in[7:0];  m_known[ad][7:0]  = 8'hFF; end
    endtask

    task automatic keep_until(input int lim);
        beat_s k[$];
        foreach (q[i]) if (q[i].t <= lim) k.push_back(q[i]);
        q = k;
    endtask

    task automatic model_edge();
        int cmd, code, cl;
        bit live, hit, anyopen;
        beat_s k[$];
        if (rst) begin model_reset(); return; end
        if (!cke) return;
        t++;
        e_oe = 0;
        foreach (q[i]) begin
            if (q[i].t == t) begin
                e_oe = !m_mask;
                e_out = m_mem[q[i].addr];
                e_known = m_known[q[i].addr];
            end
        end
        foreach (q[i]) if (q[i].t > t) k.push_back(q[i]);
        q = k;
        m_mask = |dqm;
        cmd = cs_n ? 7 : int'({ras_n, cas_n, we_n});
        live = (cmd != 7);
        anyopen = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        hit = 1; code = 0;
        if (!live) hit = 0;
        else if (t <= m_rfc_until) code = 5;
        else if ((cmd == 3 || cmd == 4 || cmd == 5) && m_init != 2) code = 1;
        else if (cmd == 3 && m_open[ba]) code = 3;
        else if ((cmd == 4 || cmd == 5) && !m_open[ba]) code = 2;
        else if ((cmd == 0 || cmd == 1) && anyopen) code = 4;
        else if (cmd == 0 && !(a[2:0] < 3'd2 && (a[6:4] == 3'd2 || a[6:4] == 3'd3))) code = 6;
        else hit = 0;
        if (hit && !m_err) begin m_err = 1; m_code = code; end
        if (m_pend && !(live && !hit && (cmd == 4 || cmd == 5))) mwrite(m_pend_addr);
        m_pend = 0;
        if (live && !hit) begin
            case (cmd)
                2: begin
                    if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
                    else m_open[ba] = 0;
                    if (m_init == 0 && a[10]) m_init = 1;
                end
                1: begin
                    m_rfc_until = t + T_RFC;
                    if (m_init == 1) m_refs++;
                end
                0: begin
                    m_bl2 = a[0]; m_cl3 = a[4]; m_ws = a[9];
                    if (m_init == 1 && m_refs >= 2) m_init = 2;
                end
                3: begin m_open[ba] = 1; m_row[ba] = int'(a); end
                5: begin
                    cl = m_cl3 ? 3 : 2;
                    keep_until(t);
                    q.push_back('{t + cl - 1, idx(ba, m_row[ba], int'(a))});
                    if (m_bl2) q.push_back('{t + cl, idx(ba, m_row[ba], int'(a) ^ 1)});
                end
                4: begin
                    keep_until(t);
                    mwrite(idx(ba, m_row[ba], int'(a)));
                    if (m_bl2 && !m_ws) begin
                        m_pend = 1;
                        m_pend_addr = idx(ba, m_row[ba], int'(a) ^ 1);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                        input logic [1:0] m, input logic [15:0] d);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b; a = ad; dqm = m; dq_in = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("dq_oe", 32'(dq_oe), 32'(e_oe));
        chk("dq_out", 32'(dq_out & e_known), 32'(e_out & e_known));
        chk("err", 32'(err), 32'(m_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; cke = 1'b1;
        nop(2);
        rst = 1'b0;
    endtask

    task automatic do_init(input logic [12:0] mode);
        step(PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        step(REF, 2'd0, 13'h0, 2'b00, 16'h0);
        nop(3);
        step(REF, 2'd0, 13'h0, 2'b00, 16'h0);
        nop(3);
        step(LMR, 2'd0, mode, 2'b00, 16'h0);
        nop(1);
    endtask

    initial begin
        int r;
        logic [1:0] b;
        logic [12:0] ad;
        logic [1:0] dm;
        logic [15:0] d;
        logic [12:0] md;
        foreach (m_known[i]) begin m_known[i] = '0; m_mem[i] = '0; end
        model_reset();

        do_reset();
        chk("rst_oe", 32'(dq_oe), 32'd0);
        chk("rst_dq", 32'(dq_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        do_init(13'h031);
        chk("init_err", 32'(err), 32'd0);

        do_reset();
        do_init(13'h037);
        chk("badmode_err", 32'(err), 32'd1);
        chk("badmode_code", 32'(err_code), 32'd6);

        do_reset();
        do_init(13'h031);
        step(ACT, 2'd1, 13'h5, 2'b00, 16'h0);
        step(WR, 2'd1, 13'h10, 2'b00, 16'hAAAA);
        step(NOP, 2'd0, 13'h0, 2'b00, 16'h5555);
        step(RD, 2'd1, 13'h10, 2'b00, 16'h0);
        nop(1);
        nop(1);
        chk("rd_b0_oe", 32'(dq_oe), 32'd1);
        chk("rd_b0", 32'(dq_out), 32'hAAAA);
        nop(1);
        chk("rd_b1_oe", 32'(dq_oe), 32'd1);
        chk("rd_b1", 32'(dq_out), 32'h5555);
        nop(1);
        chk("rd_end_oe", 32'(dq_oe), 32'd0);

        step(WR, 2'd1, 13'h20, 2'b00, 16'hBEEF);
        step(NOP, 2'd0, 13'h0, 2'b00, 16'hCAFE);
        step(WR, 2'd1, 13'h21, 2'b10, 16'h1234);
        step(NOP, 2'd0, 13'h0, 2'b00, 16'h5678);
        step(RD, 2'd1, 13'h20, 2'b00, 16'h0);
        nop(2);
        chk("odd_b0", 32'(dq_out), 32'h5678);
        nop(1);
        chk("odd_b1", 32'(dq_out), 32'hCA34);
        nop(1);

        step(RD, 2'd1, 13'h10, 2'b00, 16'h0);
        step(NOP, 2'd0, 13'h0, 2'b11, 16'h0);
        step(NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        chk("dqm_b0_oe", 32'(dq_oe), 32'd0);
        chk("dqm_b0_dq", 32'(dq_out), 32'hAAAA);
        nop(1);
        chk("dqm_b1_oe", 32'(dq_oe), 32'd1);
        chk("dqm_b1_dq", 32'(dq_out), 32'h5555);
        nop(1);

        step(RD, 2'd2, 13'h0, 2'b00, 16'h0);
        for (int i = 0; i < 4; i++) begin
            nop(1);
            chk("idle_oe", 32'(dq_oe), 32'd0);
        end
        chk("idle_code", 32'(err_code), 32'd2);

        do_reset();
        do_init(13'h031);
        step(REF, 2'd0, 13'h0, 2'b00, 16'h0);
        step(ACT, 2'd0, 13'h1, 2'b00, 16'h0);
        chk("trfc_code", 32'(err_code), 32'd5);

        do_reset();
        do_init(13'h031);
        step(ACT, 2'd1, 13'h5, 2'b00, 16'h0);
        step(RD, 2'd1, 13'h10, 2'b00, 16'h0);
        nop(2);
        chk("mid_oe", 32'(dq_oe), 32'd1);
        rst = 1'b1;
        nop(1);
        chk("mid_rst_oe", 32'(dq_oe), 32'd0);
        rst = 1'b0;
        step(RD, 2'd1, 13'h10, 2'b00, 16'h0);
        chk("noinit_code", 32'(err_code), 32'd1);

        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            md = '0;
            md[0] = 1'($urandom_range(0, 1));
            md[6:4] = $urandom_range(0, 1) ? 3'd3 : 3'd2;
            md[9] = 1'($urandom_range(0, 1));
            do_init(md);
            for (int i = 0; i < 300; i++) begin
                r = $urandom_range(0, 99);
                b = 2'($urandom_range(0, 3));
                ad = 13'($urandom);
                dm = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                d = 16'($urandom);
                cke = ($urandom_range(0, 19) != 0);
                if (r < 25) step(NOP, b, ad, dm, d);
                else if (r < 28) step(PRE, b, 13'h400, dm, d);
                else if (r < 31) step(REF, b, ad, dm, d);
                else if (r < 33) step(4'($urandom), b, ad, dm, d);
                else if (r < 34) step(LMR, b, 13'h020 | 13'($urandom_range(0, 1)), dm, d);
                else if (!m_open[b]) step(ACT, b, ad, dm, d);
                else if (r < 65) step(RD, b, ad, dm, d);
                else if (r < 92) step(WR, b, ad, dm, d);
                else step(PRE, b, ad & 13'h1BFF, dm, d);
            end
            cke = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
